bp_resolve_queue: RTL and testbench
===================================

Name: bp_resolve_queue

Overview:
- Consumer side of the gshare predictor: records every in-flight prediction at fetch, then retires predictions in program order when the backend resolves branches.
- Per resolved branch, emits a PHT training update with the index that was used at prediction time.
- On a misprediction, emits a one-cycle recovery pulse with the corrected GHR and flushes all younger, wrong-path entries.
- Sits between the fetch-side predictor and the branch-execute unit.

Parameters:
- DEPTH, 8, number of in-flight prediction slots (power of 2).
- ADDR_W, 32, branch address width.
- GHR_W, 8, global history width; also the PHT index width.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- alloc_valid  input  1  fetch has a predicted branch to record.
- alloc_ready  output  1  slot available; equals !full.
- alloc_pc  input  ADDR_W  branch address.
- alloc_ghr  input  GHR_W  GHR value used for this prediction (pre-shift).
- alloc_pred_taken  input  1  predicted direction.
- alloc_tag  output  log2(DEPTH)  slot written on the current alloc (tail pointer).
- resolve_valid  input  1  backend resolves the oldest branch.
- resolve_taken  input  1  actual outcome.
- upd_valid  output  1  PHT training strobe.
- upd_index  output  GHR_W  PHT index to train.
- upd_taken  output  1  outcome to train with.
- mispredict  output  1  one-cycle recovery pulse.
- restore_ghr  output  GHR_W  corrected GHR; valid when mispredict=1.
- count  output  log2(DEPTH)+1  occupied entries.
- empty  output  1  count==0.

Behaviour:
- Reset: head=tail=0, count=0, upd_valid=0, upd_index=0, upd_taken=0, mispredict=0, restore_ghr=0, alloc_ready=1, empty=1.
- Alloc fire is alloc_valid && alloc_ready.
  - Stores index = alloc_pc[GHR_W-1:0] ^ alloc_ghr, plus alloc_ghr and alloc_pred_taken, at tail.
  - tail increments modulo DEPTH (wraps DEPTH-1 -> 0).
- Resolve fire is resolve_valid && !empty, and always applies to the head entry.
  - resolve_valid while empty is ignored: no outputs, no state change.
- Latency: all outputs are registered.
  - The cycle after a resolve fire: upd_valid=1, upd_index=head.index, upd_taken=resolve_taken.
  - Otherwise upd_valid=0; upd_index and upd_taken hold their last values.
- Correct prediction (resolve_taken == head.pred_taken): head increments, count decrements, mispredict stays 0.
- Misprediction (resolve_taken != head.pred_taken):
  - Next cycle: mispredict=1 for exactly one cycle.
  - restore_ghr = {head.ghr[GHR_W-2:0], resolve_taken}.
  - Same edge: the whole queue is flushed; head=tail=0, count=0.
  - An alloc firing in that same cycle is discarded as wrong-path; alloc_ready stays as computed, but the entry is not kept.
- Alloc and correct resolve in the same cycle: both take effect; count is unchanged.
- No same-cycle bypass:
  - When full, alloc_ready=0 even if a resolve fires that cycle.
  - When empty, an entry allocated this cycle cannot be resolved until the next cycle.
- Reset mid-operation clears all entries and drops any pending upd_valid or mispredict on the next edge.
- Entry storage is not cleared on reset or flush; occupancy is defined by pointers and count only.

Decomposition:
- Shared package bp_pkg:
  - Constants GHR_W=8, ADDR_W=32, BPQ_DEPTH=8.
  - Typedef bpq_entry_t {idx[GHR_W], ghr[GHR_W], pred_taken}.
  - Function gshare_index(pc, ghr), also to be used by the predictor.
- One sub-module, bpq_entry_ram: DEPTH x entry register file with one write port (tail) and one asynchronous read port (head).
- Pointers, count, flush and output registers stay in bp_resolve_queue.

Test Plan:
- Reset, then alloc pc=0x0000_0013, ghr=0x05, pred=1 -> alloc_tag=0, count=1. Resolve taken=1 -> next cycle upd_valid=1, upd_index=0x16, upd_taken=1, mispredict=0, count=0.
- Alloc three entries (ghr=0x01/0x02/0x03, pred=1), resolve the first with taken=0 -> next cycle mispredict=1, restore_ghr=0x02, upd_index=pc^0x01, count=0, empty=1. mispredict is back to 0 the cycle after.
- Fill 8 entries -> alloc_ready=0. Alloc_valid plus a correct resolve in the same cycle -> no alloc, count=7. Next cycle alloc fires with alloc_tag=0, confirming pointer wrap.
- Steady alloc plus correct resolve every cycle for 20 cycles -> count is constant and upd_index sequence matches alloc order.
- resolve_valid=1 while empty -> upd_valid=0, mispredict=0, pointers unchanged.
- Assert reset with 5 entries and a mispredicting resolve in the same cycle -> next cycle count=0, mispredict=0, upd_valid=0.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared gshare predictor types, sizes and the PHT index hash.
package bp_pkg;

  localparam int unsigned GHR_W     = 8;
  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned BPQ_DEPTH = 8;

  typedef struct packed {
    logic [GHR_W-1:0] idx;
    logic [GHR_W-1:0] ghr;
    logic             pred_taken;
  } bpq_entry_t;

  // PHT index: low PC bits xor global history (truncating cast keeps pc[GHR_W-1:0]).
  function automatic logic [GHR_W-1:0] gshare_index(input logic [ADDR_W-1:0] pc,
                                                     input logic [GHR_W-1:0]  ghr);
    return GHR_W'(pc) ^ ghr;
  endfunction

endpackage

// File: rtl/bpq_entry_ram.sv
// In-flight prediction storage: one write port at the tail, async read at the head.
module bpq_entry_ram #(
  parameter int unsigned DEPTH = bp_pkg::BPQ_DEPTH
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  bp_pkg::bpq_entry_t       wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output bp_pkg::bpq_entry_t       rd_data
);
  import bp_pkg::*;

  bpq_entry_t mem_q [DEPTH];
  bpq_entry_t mem_d [DEPTH];

  // Next contents: write the tail slot when enabled; no reset, occupancy lives in pointers.
  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_addr] = wr_data;
  end

  // Storage register.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/bp_resolve_queue.sv
// In-order resolve queue for gshare predictions: trains the PHT and recovers the GHR on mispredict.
module bp_resolve_queue #(
  parameter int unsigned DEPTH  = bp_pkg::BPQ_DEPTH,
  parameter int unsigned ADDR_W = bp_pkg::ADDR_W,
  parameter int unsigned GHR_W  = bp_pkg::GHR_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alloc_valid,
  output logic                     alloc_ready,
  input  logic [ADDR_W-1:0]        alloc_pc,
  input  logic [GHR_W-1:0]         alloc_ghr,
  input  logic                     alloc_pred_taken,
  output logic [$clog2(DEPTH)-1:0] alloc_tag,
  input  logic                     resolve_valid,
  input  logic                     resolve_taken,
  output logic                     upd_valid,
  output logic [GHR_W-1:0]         upd_index,
  output logic                     upd_taken,
  output logic                     mispredict,
  output logic [GHR_W-1:0]         restore_ghr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);
  import bp_pkg::*;

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ready_q, ready_d, empty_q, empty_d;
  logic             upd_valid_q, upd_valid_d, upd_taken_q, upd_taken_d;
  logic [GHR_W-1:0] upd_index_q, upd_index_d;
  logic             mispredict_q, mispredict_d;
  logic [GHR_W-1:0] restore_q, restore_d;

  logic       alloc_fire, resolve_fire, mis;
  bpq_entry_t wr_entry, head_entry;

  assign alloc_fire   = alloc_valid && ready_q;
  assign resolve_fire = resolve_valid && !empty_q;
  assign mis          = resolve_fire && (resolve_taken != head_entry.pred_taken);

  assign wr_entry.idx        = gshare_index(alloc_pc, alloc_ghr);
  assign wr_entry.ghr        = alloc_ghr;
  assign wr_entry.pred_taken = alloc_pred_taken;

  bpq_entry_ram #(.DEPTH(DEPTH)) u_ram (
    .clk     (clk),
    .wr_en   (alloc_fire),
    .wr_addr (tail_q),
    .wr_data (wr_entry),
    .rd_addr (head_q),
    .rd_data (head_entry)
  );

  // Pointer/count update, training outputs and mispredict flush.
  always_comb begin
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    upd_valid_d  = 1'b0;
    upd_index_d  = upd_index_q;
    upd_taken_d  = upd_taken_q;
    mispredict_d = 1'b0;
    restore_d    = restore_q;

    if (resolve_fire) begin
      upd_valid_d = 1'b1;
      upd_index_d = head_entry.idx;
      upd_taken_d = resolve_taken;
    end

    if (mis) begin
      // Everything younger than the head is wrong-path, including a same-cycle alloc.
      head_d       = '0;
      tail_d       = '0;
      count_d      = '0;
      mispredict_d = 1'b1;
      restore_d    = {head_entry.ghr[GHR_W-2:0], resolve_taken};
    end else begin
      if (alloc_fire)   tail_d = tail_q + PTR_W'(1);
      if (resolve_fire) head_d = head_q + PTR_W'(1);
      count_d = count_q + CNT_W'(alloc_fire) - CNT_W'(resolve_fire);
    end

    ready_d = (count_d != CNT_W'(DEPTH));
    empty_d = (count_d == '0);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      ready_q      <= 1'b1;
      empty_q      <= 1'b1;
      upd_valid_q  <= 1'b0;
      upd_index_q  <= '0;
      upd_taken_q  <= 1'b0;
      mispredict_q <= 1'b0;
      restore_q    <= '0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      ready_q      <= ready_d;
      empty_q      <= empty_d;
      upd_valid_q  <= upd_valid_d;
      upd_index_q  <= upd_index_d;
      upd_taken_q  <= upd_taken_d;
      mispredict_q <= mispredict_d;
      restore_q    <= restore_d;
    end
  end

  assign alloc_ready = ready_q;
  assign alloc_tag   = tail_q;
  assign count       = count_q;
  assign empty       = empty_q;
  assign upd_valid   = upd_valid_q;
  assign upd_index   = upd_index_q;
  assign upd_taken   = upd_taken_q;
  assign mispredict  = mispredict_q;
  assign restore_ghr = restore_q;

endmodule

// File: tb/tb_bp_resolve_queue.sv
// Scoreboard bench for bp_resolve_queue against a queue-based reference model.
module tb_bp_resolve_queue;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        alloc_valid, alloc_ready, alloc_pred_taken;
  logic [31:0] alloc_pc;
  logic [7:0]  alloc_ghr;
  logic [2:0]  alloc_tag;
  logic        resolve_valid, resolve_taken;
  logic        upd_valid, upd_taken, mispredict, empty;
  logic [7:0]  upd_index, restore_ghr;
  logic [3:0]  count;

  bp_resolve_queue dut (
    .clk              (clk),
    .reset            (reset),
    .alloc_valid      (alloc_valid),
    .alloc_ready      (alloc_ready),
    .alloc_pc         (alloc_pc),
    .alloc_ghr        (alloc_ghr),
    .alloc_pred_taken (alloc_pred_taken),
    .alloc_tag        (alloc_tag),
    .resolve_valid    (resolve_valid),
    .resolve_taken    (resolve_taken),
    .upd_valid        (upd_valid),
    .upd_index        (upd_index),
    .upd_taken        (upd_taken),
    .mispredict       (mispredict),
    .restore_ghr      (restore_ghr),
    .count            (count),
    .empty            (empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] idx;
    logic [7:0] ghr;
    bit         pred;
  } m_entry_t;

  typedef struct {
    logic [7:0] idx;
    bit         taken;
    bit         mis;
    logic [7:0] restore;
  } exp_t;

  m_entry_t mq[$];
  exp_t     exq[$];
  int       tail_m = 0;
  int       checks = 0;
  int       errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit head_pred();
    return (mq.size() > 0) ? mq[0].pred : 1'b0;
  endfunction

  // One clock of stimulus; the model follows the behavioural rules directly.
  task automatic step(input bit rst, input bit av, input logic [31:0] pc, input logic [7:0] g,
                      input bit pt, input bit rv, input bit rt);
    bit       af, rf, mis;
    m_entry_t h, n;
    exp_t     e;
    chk("count", 32'(count), 32'(mq.size()));
    chk("alloc_ready", 32'(alloc_ready), 32'(mq.size() < DEPTH));
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("alloc_tag", 32'(alloc_tag), 32'(tail_m));
    reset            = rst;
    alloc_valid      = av;
    alloc_pc         = pc;
    alloc_ghr        = g;
    alloc_pred_taken = pt;
    resolve_valid    = rv;
    resolve_taken    = rt;
    af = av && (mq.size() < DEPTH);
    rf = rv && (mq.size() > 0);
    if (rst) begin
      mq.delete();
      tail_m = 0;
    end else begin
      mis = 1'b0;
      if (rf) begin
        h         = mq[0];
        mis       = (rt != h.pred);
        e.idx     = h.idx;
        e.taken   = rt;
        e.mis     = mis;
        e.restore = {h.ghr[6:0], rt};
        exq.push_back(e);
      end
      if (mis) begin
        mq.delete();
        tail_m = 0;
      end else begin
        if (rf) void'(mq.pop_front());
        if (af) begin
          n.idx  = pc[7:0] ^ g;
          n.ghr  = g;
          n.pred = pt;
          mq.push_back(n);
          tail_m = (tail_m + 1) % DEPTH;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 8'h0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: every training strobe is matched against the oldest expected response.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (upd_valid === 1'b1) begin
      if (exq.size() == 0) begin
        chk("unexpected_upd_valid", 32'(upd_valid), 32'h0);
      end else begin
        e = exq.pop_front();
        chk("upd_index", 32'(upd_index), 32'(e.idx));
        chk("upd_taken", 32'(upd_taken), 32'(e.taken));
        chk("mispredict", 32'(mispredict), 32'(e.mis));
        if (e.mis) chk("restore_ghr", 32'(restore_ghr), 32'(e.restore));
      end
    end else if (mispredict !== 1'b0 && reset === 1'b0) begin
      chk("stray_mispredict", 32'(mispredict), 32'h0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; alloc_valid = 0; alloc_pc = '0; alloc_ghr = '0; alloc_pred_taken = 0;
    resolve_valid = 0; resolve_taken = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_upd_valid", 32'(upd_valid), 32'h0);
    chk("rst_upd_index", 32'(upd_index), 32'h0);
    chk("rst_upd_taken", 32'(upd_taken), 32'h0);
    chk("rst_mispredict", 32'(mispredict), 32'h0);
    chk("rst_restore_ghr", 32'(restore_ghr), 32'h0);

    // Single alloc then correct resolve.
    chk("first_tag", 32'(alloc_tag), 32'h0);
    step(0, 1, 32'h0000_0013, 8'h05, 1, 0, 0);
    chk("count_one", 32'(count), 32'h1);
    step(0, 0, 32'h0, 8'h0, 0, 1, 1);
    chk("idx_0x16", 32'(upd_index), 32'h16);
    idle();

    // Mispredict on the oldest of three.
    step(0, 1, 32'h0000_0100, 8'h01, 1, 0, 0);
    step(0, 1, 32'h0000_0200, 8'h02, 1, 0, 0);
    step(0, 1, 32'h0000_0300, 8'h03, 1, 0, 0);
    step(0, 1, 32'h0000_0400, 8'h04, 1, 1, 0);
    chk("mis_pulse", 32'(mispredict), 32'h1);
    chk("mis_restore", 32'(restore_ghr), 32'h02);
    idle();
    chk("mis_drop", 32'(mispredict), 32'h0);

    // Fill, full with same-cycle resolve, then wrapped alloc.
    for (int i = 0; i < DEPTH; i++) step(0, 1, 32'(i * 7 + 3), 8'(i * 13), 1'(i), 0, 0);
    chk("full_ready", 32'(alloc_ready), 32'h0);
    step(0, 1, 32'h55, 8'h66, 1, 1, head_pred());
    chk("full_count", 32'(count), 32'h7);
    chk("wrap_tag", 32'(alloc_tag), 32'h0);
    step(0, 1, 32'h77, 8'h11, 0, 0, 0);
    step(0, 0, 32'h0, 8'h0, 0, 1, head_pred());

    // Steady alloc plus correct resolve.
    for (int i = 0; i < 20; i++)
      step(0, 1, $urandom, 8'($urandom), 1'($urandom), 1, head_pred());

    // Drain, then resolve while empty.
    for (int i = 0; i < DEPTH && mq.size() > 0; i++) step(0, 0, 32'h0, 8'h0, 0, 1, head_pred());
    step(0, 0, 32'h0, 8'h0, 0, 1, 1);
    step(0, 0, 32'h0, 8'h0, 0, 1, 0);
    idle();

    // Reset with five entries and a mispredicting resolve.
    for (int i = 0; i < 5; i++) step(0, 1, 32'(i + 40), 8'(i), 1, 0, 0);
    step(1, 1, 32'h99, 8'h99, 1, 1, 0);
    chk("rstmid_count", 32'(count), 32'h0);
    chk("rstmid_mispredict", 32'(mispredict), 32'h0);
    chk("rstmid_upd_valid", 32'(upd_valid), 32'h0);
    idle();

    // Randomized traffic with occasional mispredicts.
    for (int i = 0; i < 400; i++) begin
      bit rt;
      rt = head_pred();
      if ($urandom_range(0, 9) < 2) rt = ~rt;
      step(0, ($urandom_range(0, 9) < 6), $urandom, 8'($urandom), 1'($urandom),
           ($urandom_range(0, 9) < 5), rt);
    end
    repeat (3) idle();
    chk("scoreboard_drained", 32'(exq.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
